// File: rtl/vigenere_stream_decryptor.sv
// Receive-side Vigenere decryptor with valid/ready on both sides and one output register stage.
// The key position advances only on letters. Case is preserved and non-letters pass through.
// Ports:
//   clock, resetN   rising-edge clock, asynchronous active-low reset
//   keyInput        key string; char 0 in the top byte
//   keyLength       key chars in use (0 or >KEY_CHARS selects KEY_CHARS)
//   load            key-load strobe; flushes any pending output
//   inValid/inReady/chipherChar       ciphertext input handshake (inReady is combinational)
//   outValid/outReady/decryptedChar   plaintext output handshake (registered)
//   keyIndex        key position applied to the next letter
//   keyError        last load held a used key char outside 'A'..'Z'
module vigenere_stream_decryptor #(
  parameter int unsigned KEY_CHARS = 10,
  parameter int unsigned LEN_W     = 4
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic [8*KEY_CHARS-1:0] keyInput,
  input  logic [LEN_W-1:0]       keyLength,
  input  logic                   load,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [7:0]             chipherChar,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [7:0]             decryptedChar,
  output logic [LEN_W-1:0]       keyIndex,
  output logic                   keyError
);

  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned SUM_W   = 6;

  typedef enum logic {IDLE, RUN} stateT;

  stateT state;
  stateT stateNext;

  logic [SHIFT_W-1:0] keyShift [KEY_CHARS];
  logic [LEN_W-1:0]   keyLen;

  logic [LEN_W-1:0]   effLen;
  logic [SHIFT_W-1:0] loadShift [KEY_CHARS];
  logic               loadBad;

  logic [SHIFT_W-1:0] curShift;
  logic               isUp;
  logic               isLow;
  logic [SHIFT_W-1:0] letterOff;
  logic [SUM_W-1:0]   shiftSum;
  logic [SUM_W-1:0]   shiftMod;
  logic [7:0]         decoded;
  logic [LEN_W-1:0]   keyIndexInc;
  logic               transfer;

  function automatic logic isUpper(input logic [7:0] b);
    return (b >= 8'd65) && (b <= 8'd90);
  endfunction

  function automatic logic isLower(input logic [7:0] b);
    return (b >= 8'd97) && (b <= 8'd122);
  endfunction

  // State register
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and input-side ready
  always_comb begin
    stateNext = state;
    inReady   = 1'b0;
    case (state)
      IDLE: begin
        if (load) stateNext = RUN;
      end
      RUN: begin
        stateNext = RUN;
        inReady   = ~load & (~outValid | outReady);
      end
      default: stateNext = IDLE;
    endcase
  end

  assign transfer = inValid & inReady;

  // Key decode for a load: effective length, per-char shift, bad-char detection over used chars
  always_comb begin
    effLen  = ((keyLength == '0) || (keyLength > LEN_W'(KEY_CHARS))) ? LEN_W'(KEY_CHARS) : keyLength;
    loadBad = 1'b0;
    for (int unsigned i = 0; i < KEY_CHARS; i++) begin
      loadShift[i] = isUpper(keyInput[8*(KEY_CHARS-1-i) +: 8])
                     ? SHIFT_W'(keyInput[8*(KEY_CHARS-1-i) +: 8] - 8'd65)
                     : '0;
      if (!isUpper(keyInput[8*(KEY_CHARS-1-i) +: 8]) && (LEN_W'(i) < effLen)) begin
        loadBad = 1'b1;
      end
    end
  end

  // Select the shift for the current key position
  always_comb begin
    curShift = '0;
    for (int unsigned i = 0; i < KEY_CHARS; i++) begin
      if (keyIndex == LEN_W'(i)) curShift = keyShift[i];
    end
  end

  // Letter decode: offset + 26 - shift lies in 1..51, so one conditional subtract gives the mod
  always_comb begin
    isUp      = isUpper(chipherChar);
    isLow     = isLower(chipherChar);
    letterOff = isUp ? SHIFT_W'(chipherChar - 8'd65) : SHIFT_W'(chipherChar - 8'd97);
    shiftSum  = SUM_W'(letterOff) + SUM_W'(26) - SUM_W'(curShift);
    shiftMod  = (shiftSum >= SUM_W'(26)) ? (shiftSum - SUM_W'(26)) : shiftSum;
    if (isUp) begin
      decoded = 8'd65 + 8'(shiftMod);
    end else if (isLow) begin
      decoded = 8'd97 + 8'(shiftMod);
    end else begin
      decoded = chipherChar;
    end
    keyIndexInc = (keyIndex == (keyLen - LEN_W'(1))) ? '0 : (keyIndex + LEN_W'(1));
  end

  // Key storage, output register and key position
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < KEY_CHARS; i++) keyShift[i] <= '0;
      keyLen        <= '0;
      keyIndex      <= '0;
      keyError      <= 1'b0;
      outValid      <= 1'b0;
      decryptedChar <= 8'h00;
    end else if (load) begin
      for (int unsigned i = 0; i < KEY_CHARS; i++) keyShift[i] <= loadShift[i];
      keyLen   <= effLen;
      keyIndex <= '0;
      keyError <= loadBad;
      outValid <= 1'b0;
    end else if (transfer) begin
      decryptedChar <= decoded;
      outValid      <= 1'b1;
      if (isUp || isLow) keyIndex <= keyIndexInc;
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vigenere_stream_decryptor.sv
// Bench for vigenere_stream_decryptor: table of key/stream vectors plus hand-written
// backpressure, reload and async-reset sequences; outputs are checked through a scoreboard queue.
module tb_vigenere_stream_decryptor;

  localparam int unsigned KEY_CHARS = 10;
  localparam int unsigned LEN_W     = 4;

  logic                   clock;
  logic                   resetN;
  logic [8*KEY_CHARS-1:0] keyInput;
  logic [LEN_W-1:0]       keyLength;
  logic                   load;
  logic                   inValid;
  logic                   inReady;
  logic [7:0]             chipherChar;
  logic                   outValid;
  logic                   outReady;
  logic [7:0]             decryptedChar;
  logic [LEN_W-1:0]       keyIndex;
  logic                   keyError;

  typedef struct {
    logic [79:0] key;
    logic [3:0]  len;
    logic [63:0] cipher;
    logic [63:0] plain;
    int          n;
    logic [3:0]  endIdx;
    logic        err;
  } vecT;

  vecT        vecs [8];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] expQ [$];
  logic [7:0] expVal;

  vigenere_stream_decryptor #(.KEY_CHARS(KEY_CHARS), .LEN_W(LEN_W)) dut (
    .clock         (clock),
    .resetN        (resetN),
    .keyInput      (keyInput),
    .keyLength     (keyLength),
    .load          (load),
    .inValid       (inValid),
    .inReady       (inReady),
    .chipherChar   (chipherChar),
    .outValid      (outValid),
    .outReady      (outReady),
    .decryptedChar (decryptedChar),
    .keyIndex      (keyIndex),
    .keyError      (keyError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: an output is consumed when valid & ready at the edge and no load flushes it
  always @(negedge clock) begin
    if (resetN && outValid && outReady && !load) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected output: got %0h, required none", decryptedChar);
      end else begin
        expVal = expQ.pop_front();
        chk("scoreboard out", 32'(decryptedChar), 32'(expVal));
      end
    end
  end

  task automatic loadKey(input logic [79:0] k, input logic [3:0] l);
    load      = 1'b1;
    keyInput  = k;
    keyLength = l;
    @(posedge clock); #1;
    load = 1'b0;
  endtask

  // Present a byte, wait (bounded) for inReady, record the expectation; returns at edge+1
  task automatic sendChar(input logic [7:0] c, input logic [7:0] e, output int waits);
    inValid     = 1'b1;
    chipherChar = c;
    waits       = 0;
    @(negedge clock);
    while (!inReady && waits < 50) begin
      waits++;
      @(negedge clock);
    end
    if (!inReady) begin
      checks++;
      errors++;
      $display("FAIL accept timeout: got inReady=0, required 1");
    end else begin
      expQ.push_back(e);
    end
    @(posedge clock); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expQ.size() != 0 && t < 20) begin
      @(posedge clock); #1;
      t++;
    end
    chk("drain", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         w;
    logic [63:0] cv;
    logic [63:0] pv;
    logic [7:0]  c;
    logic [7:0]  p;

    vecs[0] = '{key:"KADIROZLEM", len:4'd10, cipher:"SSWIEPTW",     plain:"ISTANBUL",     n:8, endIdx:4'd8, err:1'b0};
    vecs[1] = '{key:"KADAAAAAAA", len:4'd3,  cipher:64'("KK KK"),   plain:64'("AK HA"),   n:5, endIdx:4'd1, err:1'b0};
    vecs[2] = '{key:"KADAAAAAAA", len:4'd3,  cipher:64'("kk kk"),   plain:64'("ak ha"),   n:5, endIdx:4'd1, err:1'b0};
    vecs[3] = '{key:"K1DAAAAAAA", len:4'd3,  cipher:64'("KKK"),     plain:64'("AKH"),     n:3, endIdx:4'd0, err:1'b1};
    vecs[4] = '{key:"KADIROZLEM", len:4'd0,  cipher:"SSWIEPTW",     plain:"ISTANBUL",     n:8, endIdx:4'd8, err:1'b0};
    vecs[5] = '{key:"KADIROZLEM", len:4'd11, cipher:"SSWIEPTW",     plain:"ISTANBUL",     n:8, endIdx:4'd8, err:1'b0};
    vecs[6] = '{key:"ZAAAAAAAAA", len:4'd1,  cipher:64'("AZa!"),    plain:64'("BAb!"),    n:4, endIdx:4'd0, err:1'b0};
    vecs[7] = '{key:"K1DAAAAAAA", len:4'd1,  cipher:64'("KK"),      plain:64'("AA"),      n:2, endIdx:4'd0, err:1'b0};

    resetN      = 1'b0;
    load        = 1'b0;
    inValid     = 1'b0;
    outReady    = 1'b1;
    keyInput    = '0;
    keyLength   = '0;
    chipherChar = 8'h00;

    #2;
    chk("reset outValid", 32'(outValid), 32'd0);
    chk("reset inReady", 32'(inReady), 32'd0);
    chk("reset keyIndex", 32'(keyIndex), 32'd0);
    chk("reset keyError", 32'(keyError), 32'd0);
    chk("reset data", 32'(decryptedChar), 32'd0);

    repeat (2) @(posedge clock);
    #1;
    resetN  = 1'b1;
    inValid = 1'b1;
    chipherChar = "S";
    @(negedge clock);
    chk("idle inReady", 32'(inReady), 32'd0);
    @(posedge clock); #1;
    inValid = 1'b0;

    for (int r = 0; r < 8; r++) begin
      loadKey(vecs[r].key, vecs[r].len);
      chk("load keyIndex", 32'(keyIndex), 32'd0);
      chk("load keyError", 32'(keyError), 32'(vecs[r].err));
      cv = vecs[r].cipher;
      pv = vecs[r].plain;
      for (int i = 0; i < vecs[r].n; i++) begin
        c = cv[8*(vecs[r].n-1-i) +: 8];
        p = pv[8*(vecs[r].n-1-i) +: 8];
        sendChar(c, p, w);
        chk("throughput stall", 32'(w), 32'd0);
        chk("latency valid", 32'(outValid), 32'd1);
        chk("latency data", 32'(decryptedChar), 32'(p));
      end
      inValid = 1'b0;
      drain();
      chk("end keyIndex", 32'(keyIndex), 32'(vecs[r].endIdx));
      chk("end keyError", 32'(keyError), 32'(vecs[r].err));
    end

    // Backpressure: 'I' must hold while outReady=0 and the next 'S' waits upstream
    loadKey("KADIROZLEM", 4'd10);
    sendChar("S", "I", w);
    outReady    = 1'b0;
    inValid     = 1'b1;
    chipherChar = "S";
    repeat (3) begin
      @(negedge clock);
      chk("stall inReady", 32'(inReady), 32'd0);
      chk("stall outValid", 32'(outValid), 32'd1);
      chk("stall data", 32'(decryptedChar), 32'("I"));
      chk("stall keyIndex", 32'(keyIndex), 32'd1);
    end
    @(posedge clock); #1;
    outReady = 1'b1;
    sendChar("S", "S", w);
    chk("resume wait", 32'(w), 32'd0);
    chk("resume data", 32'(decryptedChar), 32'("S"));

    // Reload with a pending output and a presented byte on the same edge
    sendChar("W", "T", w);
    chk("pre-reload keyIndex", 32'(keyIndex), 32'd3);
    load        = 1'b1;
    keyInput    = "KADIROZLEM";
    keyLength   = 4'd10;
    chipherChar = "W";
    @(negedge clock);
    chk("reload inReady", 32'(inReady), 32'd0);
    @(posedge clock); #1;
    load = 1'b0;
    if (expQ.size() != 0) void'(expQ.pop_back());
    chk("reload outValid", 32'(outValid), 32'd0);
    chk("reload keyIndex", 32'(keyIndex), 32'd0);
    sendChar("W", "M", w);
    chk("reload data", 32'(decryptedChar), 32'("M"));
    inValid = 1'b0;
    drain();

    // Asynchronous reset in the middle of a held output
    loadKey("K1DAAAAAAA", 4'd3);
    chk("bad key flag", 32'(keyError), 32'd1);
    outReady = 1'b0;
    sendChar("K", "A", w);
    inValid = 1'b0;
    #3;
    resetN = 1'b0;
    #1;
    chk("async outValid", 32'(outValid), 32'd0);
    chk("async inReady", 32'(inReady), 32'd0);
    chk("async keyIndex", 32'(keyIndex), 32'd0);
    chk("async keyError", 32'(keyError), 32'd0);
    chk("async data", 32'(decryptedChar), 32'd0);
    expQ.delete();
    @(posedge clock); #1;
    resetN   = 1'b1;
    outReady = 1'b1;
    inValid  = 1'b1;
    @(negedge clock);
    chk("post-reset inReady", 32'(inReady), 32'd0);
    @(posedge clock); #1;
    inValid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
